// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared size codes, FSM encoding and alignment rule for the LSU
//
// Purpose : access-size encodings, LSU state type and the misalignment check
//           shared by riscv_lsu and riscv_lsu_align.
// Ports   : none (package).
package riscv_lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE      = 2'd0,
    LSU_ACCESS    = 2'd1,
    LSU_LOAD_WAIT = 2'd2
  } lsu_state_t;

  // Bytes are always aligned; halves need an even address; words need
  // word alignment. The reserved size code is always an error.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      LSU_SIZE_B: bad = 1'b0;
      LSU_SIZE_H: bad = off[0];
      LSU_SIZE_W: bad = (off != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - combinational lane mask, store shift, load extract/extend, error
//
// Purpose : pure datapath helper for the LSU.
// Ports   : size, off         access size and byte offset within the word
//           is_unsigned       zero-extend loads when set
//           wdata             right-justified store data
//           ram_dout          raw RAM read word
//           err               misaligned or illegal size
//           lane_mask         byte-lane enables for the access
//           store_data        store data shifted into its lanes
//           load_data         extracted and extended load result
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_dout,
  output logic        err,
  output logic [3:0]  lane_mask,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] dout_shifted;

  always_comb begin
    err          = lsu_misaligned(size, off);
    store_data   = wdata << {off, 3'b000};
    dout_shifted = ram_dout >> {off, 3'b000};
    lane_mask    = 4'b1111;
    load_data    = ram_dout;
    case (size)
      LSU_SIZE_B: begin
        lane_mask = 4'b0001 << off;
        load_data = is_unsigned ? {24'd0, dout_shifted[7:0]}
                                : {{24{dout_shifted[7]}}, dout_shifted[7:0]};
      end
      LSU_SIZE_H: begin
        lane_mask = 4'b0011 << off;
        load_data = is_unsigned ? {16'd0, dout_shifted[15:0]}
                                : {{16{dout_shifted[15]}}, dout_shifted[15:0]};
      end
      default: begin
        lane_mask = 4'b1111;
        load_data = ram_dout;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit between execute stage and synchronous-read data RAM
//
// Purpose : accepts one request at a time, drives RAM address/lane enables/data,
//           waits the RAM read latency and returns extended load data.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           req_*                     request handshake and fields from execute
//           resp_valid/err/rdata/rd   one-cycle completion pulse and payload
//           ram_addr/wea/din          word address, byte write enables, lane data
//           ram_dout                  RAM read data, one cycle after ram_addr
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int RAM_ADDR_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic [4:0]            resp_rd,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [3:0]            ram_wea,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  lsu_state_t  state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        unsigned_q;
  logic [4:0]  rd_q;
  logic        ack_in_access_q;  // store or error: completes in ACCESS

  logic [1:0]  a_size;
  logic [1:0]  a_off;
  logic        a_uns;
  logic        a_err;
  logic [3:0]  a_mask;
  logic [31:0] a_store;
  logic [31:0] a_load;
  logic        transfer;

  // Address bits above the RAM window alias and are deliberately dropped.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:RAM_ADDR_W+2];

  assign transfer = req_valid && req_ready;

  // One aligner serves both directions: in IDLE it looks at the incoming
  // request (mask/shift/err get registered on transfer); afterwards it sees
  // the latched request so the load extract lines up with ram_dout.
  assign a_size = (state == LSU_IDLE) ? req_size        : size_q;
  assign a_off  = (state == LSU_IDLE) ? req_addr[1:0]   : off_q;
  assign a_uns  = (state == LSU_IDLE) ? req_unsigned    : unsigned_q;

  riscv_lsu_align u_align (
    .size        (a_size),
    .off         (a_off),
    .is_unsigned (a_uns),
    .wdata       (req_wdata),
    .ram_dout    (ram_dout),
    .err         (a_err),
    .lane_mask   (a_mask),
    .store_data  (a_store),
    .load_data   (a_load)
  );

  // RAM read data only exists in the LOAD_WAIT cycle, so the load result is
  // taken straight from ram_dout rather than registered a cycle later.
  assign resp_rdata = (state == LSU_LOAD_WAIT) ? a_load : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= LSU_IDLE;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rd         <= 5'd0;
      ram_addr        <= '0;
      ram_wea         <= 4'd0;
      ram_din         <= 32'd0;
      size_q          <= 2'd0;
      off_q           <= 2'd0;
      unsigned_q      <= 1'b0;
      rd_q            <= 5'd0;
      ack_in_access_q <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rd    <= 5'd0;
      ram_wea    <= 4'd0;
      case (state)
        LSU_IDLE: begin
          if (transfer) begin
            size_q          <= req_size;
            off_q           <= req_addr[1:0];
            unsigned_q      <= req_unsigned;
            rd_q            <= req_rd;
            ack_in_access_q <= req_we || a_err;
            ram_addr        <= req_addr[RAM_ADDR_W+1:2];
            ram_din         <= a_store;
            ram_wea         <= (req_we && !a_err) ? a_mask : 4'd0;
            // Stores and errors answer during ACCESS itself.
            if (req_we || a_err) begin
              resp_valid <= 1'b1;
              resp_err   <= a_err;
              resp_rd    <= req_rd;
            end
            req_ready <= 1'b0;
            state     <= LSU_ACCESS;
          end
        end
        LSU_ACCESS: begin
          if (ack_in_access_q) begin
            req_ready <= 1'b1;
            state     <= LSU_IDLE;
          end else begin
            resp_valid <= 1'b1;
            resp_rd    <= rd_q;
            state      <= LSU_LOAD_WAIT;
          end
        end
        LSU_LOAD_WAIT: begin
          req_ready <= 1'b1;
          state     <= LSU_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu with RAM model and response scoreboard
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wea;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  logic        mon_en = 1'b0;
  logic [31:0] mem [0:16383];

  riscv_lsu #(.RAM_ADDR_W(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .ram_addr     (ram_addr),
    .ram_wea      (ram_wea),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read, byte-writable RAM model.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_wea[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
    ram_dout <= mem[ram_addr];
  end

  // Response monitor: pops the scoreboard on each resp_valid, and requires
  // the resp payload to be zero in every other cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: got err=%0b rdata=%h rd=%0d, required no response",
                   resp_err, resp_rdata, resp_rd);
        end else begin
          mon_e = sb.pop_front();
          if (resp_err !== mon_e.err || resp_rdata !== mon_e.rdata || resp_rd !== mon_e.rd) begin
            errors++;
            $display("FAIL resp_payload: got err=%0b rdata=%h rd=%0d, required err=%0b rdata=%h rd=%0d",
                     resp_err, resp_rdata, resp_rd, mon_e.err, mon_e.rdata, mon_e.rd);
          end
        end
      end else if (resp_err !== 1'b0 || resp_rdata !== 32'd0 || resp_rd !== 5'd0) begin
        errors++;
        $display("FAIL resp_idle_zero: got err=%0b rdata=%h rd=%0d, required all zero",
                 resp_err, resp_rdata, resp_rd);
      end
    end
  end

  // Issues one request once req_ready is seen; returns at the N+1 sample point.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                      input logic push, input logic exp_err, input logic [31:0] exp_rdata);
    int guard = 0;
    exp_t e;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: got req_ready=%0b, required 1", req_ready);
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    if (push) begin
      e.err   = exp_err;
      e.rdata = exp_rdata;
      e.rd    = rd;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0 ||
        resp_rd !== 5'd0 || ram_wea !== 4'd0 || ram_addr !== 14'd0 || ram_din !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b rv=%0b re=%0b rdata=%h rd=%0d wea=%b addr=%h din=%h, required ready=1 others 0",
               req_ready, resp_valid, resp_err, resp_rdata, resp_rd, ram_wea, ram_addr, ram_din);
    end
  endtask

  task automatic test_store_word();
    send(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 1'b1, 1'b0, 32'd0);
    checks++;
    if (ram_addr !== 14'h40 || ram_wea !== 4'b1111 || ram_din !== 32'hDEADBEEF ||
        resp_valid !== 1'b1 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_access: got addr=%h wea=%b din=%h rv=%0b re=%0b ready=%0b, required 40 1111 deadbeef 1 0 0",
               ram_addr, ram_wea, ram_din, resp_valid, resp_err, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || ram_wea !== 4'd0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL sw_after: got ready=%0b wea=%b rv=%0b, required 1 0000 0", req_ready, ram_wea, resp_valid);
    end
    checks++;
    if (mem[14'h40] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_mem: got %h, required deadbeef", mem[14'h40]);
    end
  endtask

  task automatic test_store_byte();
    send(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 5'd4, 1'b1, 1'b0, 32'd0);
    checks++;
    if (ram_wea !== 4'b1000 || ram_din[31:24] !== 8'hAB || ram_addr !== 14'h40 ||
        resp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL sb_access: got wea=%b din=%h addr=%h rv=%0b ready=%0b, required 1000 ab.. 40 1 0",
               ram_wea, ram_din, ram_addr, resp_valid, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || mem[14'h40] !== 32'hABADBEEF) begin
      errors++;
      $display("FAIL sb_after: got ready=%0b mem=%h, required 1 abadbeef", req_ready, mem[14'h40]);
    end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [5] = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h200};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80C0, 32'h00001234, 32'h80C01234};
    mem[14'h80] = 32'h80C01234;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, sizes[i], unss[i], addrs[i], 32'hFFFFFFFF, 5'(5 + i), 1'b1, 1'b0, exps[i]);
      checks++;
      if (resp_valid !== 1'b0 || ram_wea !== 4'd0 || ram_addr !== 14'h80) begin
        errors++;
        $display("FAIL load_access_%0d: got rv=%0b wea=%b addr=%h, required 0 0000 80", i, resp_valid, ram_wea, ram_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || ram_wea !== 4'd0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_wait_%0d: got rv=%0b wea=%b ready=%0b, required 1 0000 0", i, resp_valid, ram_wea, req_ready);
      end
    end
  endtask

  task automatic test_errors();
    logic        wes   [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] addrs [3] = '{32'h101, 32'h102, 32'h100};
    for (int i = 0; i < 3; i++) begin
      send(wes[i], sizes[i], 1'b0, addrs[i], 32'h12345678, 5'(20 + i), 1'b1, 1'b1, 32'd0);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || ram_wea !== 4'd0) begin
        errors++;
        $display("FAIL err_access_%0d: got rv=%0b re=%0b wea=%b, required 1 1 0000", i, resp_valid, resp_err, ram_wea);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL err_no_wait_%0d: got rv=%0b ready=%0b, required 0 1", i, resp_valid, req_ready);
      end
    end
    checks++;
    if (mem[14'h40] !== 32'hABADBEEF) begin
      errors++;
      $display("FAIL err_mem_untouched: got %h, required abadbeef", mem[14'h40]);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 5'd30, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ram_wea !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: got ready=%0b rv=%0b wea=%b, required 1 0 0000", req_ready, resp_valid, ram_wea);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h200, 32'h204, 32'h208};
    logic [1:0]  sizes [3] = '{2'b10, 2'b10, 2'b00};
    logic [31:0] exps  [3] = '{32'h80C01234, 32'h11223344, 32'hFFFFFFF7};
    int   acc [3];
    int   start_cnt;
    int   guard;
    exp_t e;
    mem[14'h81] = 32'h11223344;
    mem[14'h82] = 32'h000000F7;
    start_cnt = resp_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_we       = 1'b0;
      req_size     = sizes[i];
      req_unsigned = 1'b0;
      req_addr     = addrs[i];
      req_rd       = 5'(10 + i);
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_timeout_%0d: got req_ready=%0b, required 1", i, req_ready);
      end
      e.err   = 1'b0;
      e.rdata = exps[i];
      e.rd    = 5'(10 + i);
      sb.push_back(e);
      @(posedge clk); #1;
      acc[i] = cyc;
    end
    req_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 3) begin
        errors++;
        $display("FAIL b2b_spacing_%0d: got %0d cycles, required 3", i, acc[i] - acc[i-1]);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (resp_cnt - start_cnt !== 3) begin
      errors++;
      $display("FAIL b2b_resp_count: got %0d, required 3", resp_cnt - start_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_store_word();
    test_store_byte();
    test_loads();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
